// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the 8N1 serial link blocks (uart_rx, uart_tx).
//   uart_rx_state_t : receiver FSM state encoding.
//   UART_DATA_BITS  : data bits per frame.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte-side bus of the receiver.
//   data_out  : last good byte received.
//   rx_valid  : 1-cycle strobe, data_out updated this cycle.
//   frame_err : 1-cycle strobe, stop bit sampled low.
//   rx_busy   : receiver is not idle.
// Modports: master = receiver (drives), slave = byte consumer (reads).
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] data_out;
    logic                      rx_valid;
    logic                      frame_err;
    logic                      rx_busy;

    modport master (
        output data_out,
        output rx_valid,
        output frame_err,
        output rx_busy
    );

    modport slave (
        input data_out,
        input rx_valid,
        input frame_err,
        input rx_busy
    );

endinterface

// File: rtl/uart_sync.sv
// uart_sync: 2-flop synchroniser for an asynchronous level input.
//   clk     : destination clock.
//   reset_n : asynchronous active-low reset; both flops reset to 1 (idle line).
//   d       : asynchronous input.
//   q       : synchronised output.
module uart_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Deserialises rx into bytes, CLK_PER_BIT clocks
// per bit, LSB first, idle-high line.
//   clk     : system clock, posedge.
//   reset_n : asynchronous active-low reset.
//   rx      : serial input, asynchronous to clk.
//   bus     : uart_rx_if.master (data_out, rx_valid, frame_err, rx_busy).
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_PER_BIT = 10
) (
    input  logic      clk,
    input  logic      reset_n,
    input  logic      rx,
    uart_rx_if.master bus
);

    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST    = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state;
    logic [CW-1:0]             clk_count;
    logic [2:0]                bit_index;
    logic [UART_DATA_BITS-1:0] shift_reg;
    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q;
    logic                      ferr_q;
    logic                      rx_s;

    uart_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    // START waits half a bit so every later sample lands mid-bit; DATA/STOP
    // then step one full bit period per sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            clk_count <= '0;
            bit_index <= '0;
            shift_reg <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                IDLE: begin
                    clk_count <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (clk_count == HALF_M1) begin
                        clk_count <= '0;
                        bit_index <= '0;
                        state     <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_count == LAST) begin
                        clk_count            <= '0;
                        shift_reg[bit_index] <= rx_s;
                        if (bit_index == LAST_BIT) state <= STOP;
                        else bit_index <= bit_index + 3'd1;
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_count == LAST) begin
                        clk_count <= '0;
                        if (rx_s) begin
                            data_q  <= shift_reg;
                            valid_q <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= WAIT_HIGH;
                        end
                    end else begin
                        clk_count <= clk_count + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not be taken as a new start bit.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = (state != IDLE);

endmodule
